sbus_arb: RTL and testbench

SBUS_ARB -- requirements
Module: sbus_arb

---
 rtl/sbus_arb.sv | 210 +++++++++++++++++++++
 tb/tb_sbus_arb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbus_arb.sv
// Two-requester SBUS arbiter: grants the bus, issues START/RQ/ADR, counts ACKN and
// DATA_VALID strobes, and returns read words, DONE or a timeout NXM. Bit [0] of the
// PDP-10 style fields [0:35]/[12:35] is the MSB here, so ADR[34:35] is ADR[1:0].
module sbus_arb #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic        CLK,
  input  logic        CROBAR_N,
  input  logic [1:0]  REQ,
  input  logic [3:0]  REQ_RQ0,
  input  logic [3:0]  REQ_RQ1,
  input  logic [23:0] REQ_ADR0,
  input  logic [23:0] REQ_ADR1,
  output logic [1:0]  GNT,
  output logic [1:0]  DONE,
  output logic [1:0]  NXM,
  output logic [1:0]  RD_VALID,
  output logic [35:0] RD_DATA,
  output logic [1:0]  RD_WO,
  output logic        PAR_ERR,
  output logic        START,
  output logic [3:0]  RQ,
  output logic [23:0] ADR,
  input  logic        ACKN,
  input  logic        DATA_VALID,
  input  logic [35:0] D,
  input  logic        DATA_PAR
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  // The START cycle is the first silent cycle, so NXM lands TIMEOUT cycles after START.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_XFER   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          win_q, win_d;
  logic          last_q, last_d;
  logic [2:0]    ack_left_q, ack_left_d;
  logic [2:0]    words_left_q, words_left_d;
  logic [1:0]    wo_q, wo_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    nxm_q, nxm_d;
  logic [1:0]    rd_valid_q, rd_valid_d;
  logic [35:0]   rd_data_q, rd_data_d;
  logic [1:0]    rd_wo_q, rd_wo_d;
  logic          par_err_q, par_err_d;
  logic          start_q, start_d;
  logic [3:0]    rq_q, rq_d;
  logic [23:0]   adr_q, adr_d;

  logic          pick;
  logic [3:0]    sel_rq;
  logic [23:0]   sel_adr;
  logic [1:0]    win_oh;
  logic          ack_hit;
  logic          data_hit;

  function automatic logic [2:0] pop4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    last_d       = last_q;
    ack_left_d   = ack_left_q;
    words_left_d = words_left_q;
    wo_d         = wo_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    done_d       = 2'b00;
    nxm_d        = 2'b00;
    rd_valid_d   = 2'b00;
    rd_data_d    = rd_data_q;
    rd_wo_d      = rd_wo_q;
    par_err_d    = 1'b0;
    start_d      = 1'b0;
    rq_d         = rq_q;
    adr_d        = adr_q;
    pick         = 1'b0;
    sel_rq       = REQ_RQ0;
    sel_adr      = REQ_ADR0;
    win_oh       = win_q ? 2'b10 : 2'b01;
    ack_hit      = 1'b0;
    data_hit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt_d = 2'b00;
        if (|REQ) begin
          // On a tie the requester not served last wins.
          pick         = (REQ == 2'b11) ? ~last_q : REQ[1];
          sel_rq       = pick ? REQ_RQ1 : REQ_RQ0;
          sel_adr      = pick ? REQ_ADR1 : REQ_ADR0;
          win_d        = pick;
          last_d       = pick;
          rq_d         = sel_rq;
          adr_d        = sel_adr;
          ack_left_d   = pop4(sel_rq);
          words_left_d = pop4(sel_rq);
          wo_d         = sel_adr[1:0];
          gnt_d        = pick ? 2'b10 : 2'b01;
          if (sel_rq == 4'b0000) begin
            done_d  = pick ? 2'b10 : 2'b01;
            state_d = S_FINISH;
          end else begin
            start_d = 1'b1;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_XFER;
      end
      S_XFER: begin
        ack_hit  = ACKN && (ack_left_q != 3'd0);
        data_hit = DATA_VALID && (words_left_q != 3'd0);
        if (ack_hit) ack_left_d = ack_left_q - 3'd1;
        if (data_hit) begin
          words_left_d = words_left_q - 3'd1;
          rd_valid_d   = win_oh;
          rd_data_d    = D;
          rd_wo_d      = wo_q;
          wo_d         = wo_q + 2'd1;
          par_err_d    = ~^{D, DATA_PAR};
        end
        if (ack_left_d == 3'd0 && words_left_d == 3'd0) begin
          done_d  = win_oh;
          state_d = S_FINISH;
        end else if (ACKN || DATA_VALID) begin
          cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
          nxm_d   = win_oh;
          gnt_d   = 2'b00;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FINISH: begin
        // Terminal cycle of every transaction; REQ is not sampled here, giving the dead cycle.
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      state_q      <= S_IDLE;
      win_q        <= 1'b0;
      last_q       <= 1'b1;
      ack_left_q   <= 3'd0;
      words_left_q <= 3'd0;
      wo_q         <= 2'd0;
      cnt_q        <= '0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      nxm_q        <= 2'b00;
      rd_valid_q   <= 2'b00;
      rd_data_q    <= 36'd0;
      rd_wo_q      <= 2'd0;
      par_err_q    <= 1'b0;
      start_q      <= 1'b0;
      rq_q         <= 4'd0;
      adr_q        <= 24'd0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      last_q       <= last_d;
      ack_left_q   <= ack_left_d;
      words_left_q <= words_left_d;
      wo_q         <= wo_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      nxm_q        <= nxm_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_wo_q      <= rd_wo_d;
      par_err_q    <= par_err_d;
      start_q      <= start_d;
      rq_q         <= rq_d;
      adr_q        <= adr_d;
    end
  end

  assign GNT      = gnt_q;
  assign DONE     = done_q;
  assign NXM      = nxm_q;
  assign RD_VALID = rd_valid_q;
  assign RD_DATA  = rd_data_q;
  assign RD_WO    = rd_wo_q;
  assign PAR_ERR  = par_err_q;
  assign START    = start_q;
  assign RQ       = rq_q;
  assign ADR      = adr_q;

endmodule

// File: tb/tb_sbus_arb.sv
// Scoreboard bench for sbus_arb: stimulus pushes expected SBUS events with their
// cycle numbers; a forked monitor pops and compares whenever the DUT emits one.
module tb_sbus_arb;

  logic        CLK;
  logic        CROBAR_N;
  logic [1:0]  REQ;
  logic [3:0]  REQ_RQ0, REQ_RQ1;
  logic [23:0] REQ_ADR0, REQ_ADR1;
  logic [1:0]  GNT, DONE, NXM, RD_VALID;
  logic [35:0] RD_DATA;
  logic [1:0]  RD_WO;
  logic        PAR_ERR, START;
  logic [3:0]  RQ;
  logic [23:0] ADR;
  logic        ACKN, DATA_VALID;
  logic [35:0] D;
  logic        DATA_PAR;

  sbus_arb #(.TIMEOUT(31)) dut (
    .CLK(CLK), .CROBAR_N(CROBAR_N), .REQ(REQ),
    .REQ_RQ0(REQ_RQ0), .REQ_RQ1(REQ_RQ1), .REQ_ADR0(REQ_ADR0), .REQ_ADR1(REQ_ADR1),
    .GNT(GNT), .DONE(DONE), .NXM(NXM), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
    .RD_WO(RD_WO), .PAR_ERR(PAR_ERR), .START(START), .RQ(RQ), .ADR(ADR),
    .ACKN(ACKN), .DATA_VALID(DATA_VALID), .D(D), .DATA_PAR(DATA_PAR)
  );

  localparam int K_START = 0;
  localparam int K_RDV   = 1;
  localparam int K_DONE  = 2;
  localparam int K_NXM   = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [1:0]  pulse;
    logic [1:0]  gnt;
    logic [3:0]  rq;
    logic [23:0] adr;
    logic [35:0] data;
    logic [1:0]  wo;
    logic        perr;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_START: return "start";
      K_RDV:   return "rdvalid";
      K_DONE:  return "done";
      default: return "nxm";
    endcase
  endfunction

  function automatic int popc(input logic [3:0] m);
    int n = 0;
    for (int i = 0; i < 4; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic logic [35:0] word(input int who, input int k);
    return {8'(who + 1), 20'hC3A5F, 8'(k * 17 + 3)};
  endfunction

  task automatic push(input int kind, input int c, input logic [1:0] pulse, input logic [1:0] gnt,
                      input logic [3:0] rq, input logic [23:0] adr, input logic [35:0] data,
                      input logic [1:0] wo, input logic perr);
    ev_t e;
    e.kind = kind; e.cyc = c; e.pulse = pulse; e.gnt = gnt; e.rq = rq;
    e.adr = adr; e.data = data; e.wo = wo; e.perr = perr;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_ev(input int kind);
    ev_t a, e;
    a.kind  = kind;
    a.cyc   = cyc;
    a.gnt   = GNT;
    a.pulse = (kind == K_RDV) ? RD_VALID : (kind == K_DONE) ? DONE : (kind == K_NXM) ? NXM : 2'b00;
    a.rq    = (kind == K_START) ? RQ : 4'd0;
    a.adr   = (kind == K_START) ? ADR : 24'd0;
    a.data  = (kind == K_RDV) ? RD_DATA : 36'd0;
    a.wo    = (kind == K_RDV) ? RD_WO : 2'd0;
    a.perr  = (kind == K_RDV) ? PAR_ERR : 1'b0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL ev_%s unexpected at cyc=%0d gnt=%b", kname(kind), cyc, GNT);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != a.kind || e.cyc != a.cyc || e.pulse !== a.pulse || e.gnt !== a.gnt ||
        e.rq !== a.rq || e.adr !== a.adr || e.data !== a.data || e.wo !== a.wo || e.perr !== a.perr) begin
      bad++;
      $display("FAIL ev_%s got: cyc=%0d pulse=%b gnt=%b rq=%b adr=%h data=%h wo=%0d perr=%b | expected: %s cyc=%0d pulse=%b gnt=%b rq=%b adr=%h data=%h wo=%0d perr=%b",
               kname(a.kind), a.cyc, a.pulse, a.gnt, a.rq, a.adr, a.data, a.wo, a.perr,
               kname(e.kind), e.cyc, e.pulse, e.gnt, e.rq, e.adr, e.data, e.wo, e.perr);
    end else begin
      $display("ev %s cyc=%0d pulse=%b gnt=%b ok", kname(a.kind), a.cyc, a.pulse, a.gnt);
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge CLK);
      if (CROBAR_N) begin
        if (START) check_ev(K_START);
        if (|RD_VALID) check_ev(K_RDV);
        if (|DONE) check_ev(K_DONE);
        if (|NXM) check_ev(K_NXM);
        if (PAR_ERR && RD_VALID == 2'b00) begin
          total++;
          bad++;
          $display("FAIL par_err_alone got=1 expected=0 cyc=%0d", cyc);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called one cycle into IDLE; returns one cycle into IDLE after DONE.
  task automatic do_txn(input int who, input logic [1:0] req, input logic [1:0] req_mid,
                        input logic [1:0] req_end, input bit coinc, input int bad_k);
    logic [3:0]  rq;
    logic [23:0] adr;
    logic [1:0]  oh;
    logic [35:0] w;
    int n, c, k;
    oh  = (who == 1) ? 2'b10 : 2'b01;
    rq  = (who == 1) ? REQ_RQ1 : REQ_RQ0;
    adr = (who == 1) ? REQ_ADR1 : REQ_ADR0;
    n   = popc(rq);
    c   = cyc;
    REQ = req;
    if (n == 0) begin
      push(K_DONE, c + 1, oh, oh, 4'd0, 24'd0, 36'd0, 2'd0, 1'b0);
      tick();
      REQ = req_end;
      tick();
      return;
    end
    push(K_START, c + 1, 2'b00, oh, rq, adr, 36'd0, 2'd0, 1'b0);
    for (int i = 0; i < n; i++)
      push(K_RDV, coinc ? c + 3 + i : c + 4 + i, oh, oh, 4'd0, 24'd0, word(who, i),
           2'(adr[1:0] + 2'(i)), (i == bad_k));
    push(K_DONE, coinc ? c + 2 + n : c + 3 + n, oh, oh, 4'd0, 24'd0, 36'd0, 2'd0, 1'b0);
    tick();
    REQ = req_mid;
    tick();
    for (int s = 0; s < n + (coinc ? 0 : 1); s++) begin
      ACKN       = (s < n);
      DATA_VALID = coinc ? 1'b1 : (s >= 1);
      k          = coinc ? s : s - 1;
      if (DATA_VALID) begin
        w        = word(who, k);
        D        = w;
        DATA_PAR = (k == bad_k) ? ^w : ~^w;
      end
      tick();
    end
    ACKN       = 1'b0;
    DATA_VALID = 1'b0;
    REQ        = req_end;
    tick();
  endtask

  initial begin
    int c;
    logic [35:0] w;
    CROBAR_N = 1'b0;
    REQ = 2'b00;
    REQ_RQ0 = 4'd0; REQ_RQ1 = 4'd0; REQ_ADR0 = 24'd0; REQ_ADR1 = 24'd0;
    ACKN = 1'b0; DATA_VALID = 1'b0; D = 36'd0; DATA_PAR = 1'b0;
    fork
      monitor_loop();
    join_none
    repeat (2) tick();
    chk("rst_gnt", 64'(GNT), 64'd0);
    chk("rst_start", 64'(START), 64'd0);
    chk("rst_rd_data", 64'(RD_DATA), 64'd0);
    chk("rst_adr", 64'(ADR), 64'd0);
    CROBAR_N = 1'b1;
    tick();

    // REQ=11 held: grants alternate 0,1,0 with one dead cycle between.
    REQ_RQ0 = 4'b0011; REQ_ADR0 = 24'h000104;
    REQ_RQ1 = 4'b1000; REQ_ADR1 = 24'h000207;
    do_txn(0, 2'b11, 2'b11, 2'b11, 1'b0, -1);
    do_txn(1, 2'b11, 2'b11, 2'b11, 1'b1, -1);
    do_txn(0, 2'b11, 2'b11, 2'b00, 1'b0, -1);

    // Four-word read from octal 00001002: offsets 2,3,0,1.
    REQ_RQ0 = 4'b1111; REQ_ADR0 = 24'o00001002;
    do_txn(0, 2'b01, 2'b01, 2'b00, 1'b0, -1);

    // Requester 1, mask 0101, coincident strobes, REQ dropped mid-transfer.
    REQ_RQ1 = 4'b0101; REQ_ADR1 = 24'h00ABC1;
    do_txn(1, 2'b10, 2'b00, 2'b00, 1'b1, -1);

    // Second word with even parity.
    REQ_RQ0 = 4'b0111; REQ_ADR0 = 24'h001233;
    do_txn(0, 2'b01, 2'b01, 2'b00, 1'b0, 1);

    // Empty mask: DONE next cycle, no START.
    REQ_RQ1 = 4'b0000; REQ_ADR1 = 24'h000555;
    do_txn(1, 2'b10, 2'b10, 2'b00, 1'b0, -1);

    // Strobes while idle are ignored.
    ACKN = 1'b1; DATA_VALID = 1'b1; D = 36'h123456789;
    tick();
    tick();
    chk("idle_strobe_rdvalid", 64'(RD_VALID), 64'd0);
    ACKN = 1'b0; DATA_VALID = 1'b0;
    tick();

    // Silent memory: NXM[0] 31 cycles after START, GNT dropped, no DONE.
    REQ_RQ0 = 4'b1111; REQ_ADR0 = 24'h000400;
    c = cyc;
    REQ = 2'b01;
    push(K_START, c + 1, 2'b00, 2'b01, 4'b1111, 24'h000400, 36'd0, 2'd0, 1'b0);
    push(K_NXM, c + 32, 2'b01, 2'b00, 4'd0, 24'd0, 36'd0, 2'd0, 1'b0);
    while (cyc < c + 32) tick();
    REQ = 2'b00;
    tick();

    // Reset during XFER after requester 0 was served last.
    REQ_RQ0 = 4'b1111; REQ_ADR0 = 24'h00F0F1;
    c = cyc;
    REQ = 2'b01;
    w = word(0, 0);
    push(K_START, c + 1, 2'b00, 2'b01, 4'b1111, 24'h00F0F1, 36'd0, 2'd0, 1'b0);
    push(K_RDV, c + 4, 2'b01, 2'b01, 4'd0, 24'd0, w, 2'd1, 1'b0);
    tick();
    tick();
    ACKN = 1'b1;
    tick();
    ACKN = 1'b0; DATA_VALID = 1'b1; D = w; DATA_PAR = ~^w;
    tick();
    DATA_VALID = 1'b0;
    @(negedge CLK);
    #2;
    CROBAR_N = 1'b0;
    REQ = 2'b00;
    #1;
    chk("arst_gnt", 64'(GNT), 64'd0);
    chk("arst_rd_valid", 64'(RD_VALID), 64'd0);
    chk("arst_rd_data", 64'(RD_DATA), 64'd0);
    chk("arst_rd_wo", 64'(RD_WO), 64'd0);
    chk("arst_rq", 64'(RQ), 64'd0);
    chk("arst_adr", 64'(ADR), 64'd0);
    chk("arst_done_nxm", 64'({DONE, NXM, PAR_ERR, START}), 64'd0);
    tick();
    CROBAR_N = 1'b1;
    REQ_RQ0 = 4'b1001; REQ_ADR0 = 24'h000010;
    REQ_RQ1 = 4'b0110; REQ_ADR1 = 24'h000020;
    do_txn(0, 2'b11, 2'b11, 2'b00, 1'b1, -1);

    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
